reset_sequencer: RTL and testbench

//  Parametrised successor to the fixed clock/reset stub: turns one raw async reset plus a
//  PLL/MMCM lock flag into NUM_CH synchronous resets released in a fixed order.

---
 rtl/reset_sequencer.sv | 157 +++++++++++++++
 tb/tb_reset_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
`timescale 1ns / 1ps
// reset_sequencer
// Turns one raw asynchronous reset plus a PLL/MMCM lock flag into NUM_CH
// synchronous active-high resets. The resets are released one at a time, in
// channel order, and each channel has its own programmable delay. Losing lock
// or requesting a soft reset re-asserts every output and reruns the sequence.
// ready is high only once every channel has been released.
module reset_sequencer #(
  parameter int                        NUM_CH        = 2,
  parameter int                        DELAY_W       = 16,
  parameter logic [NUM_CH*DELAY_W-1:0] RELEASE_DELAY = {16'd8, 16'd4},
  parameter int                        HOLD_CYCLES   = 16,
  parameter int                        SYNC_STAGES   = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_locked,
  input  logic               soft_reset,
  output logic [NUM_CH-1:0]  out_reset,
  output logic               ready,
  output logic [DELAY_W-1:0] busy_cnt
);

  localparam int                 IDX_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [DELAY_W-1:0] HOLD_LAST = DELAY_W'(HOLD_CYCLES - 1);
  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_CH - 1);

  typedef enum logic [1:0] {
    S_HOLD,
    S_WAIT_LOCK,
    S_RELEASE,
    S_RUN
  } state_t;

  // Reject parameter sets the sequencer cannot honour.
  if (NUM_CH < 1) begin : g_bad_num_ch
    $error("reset_sequencer: NUM_CH must be at least 1");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("reset_sequencer: HOLD_CYCLES must be at least 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("reset_sequencer: SYNC_STAGES must be at least 2");
  end
  if ((longint'(HOLD_CYCLES) - 1) > ((longint'(1) << DELAY_W) - 1)) begin : g_bad_hold_w
    $error("reset_sequencer: HOLD_CYCLES-1 does not fit in DELAY_W bits");
  end

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_locked_s;
  state_t                 r_state;
  logic [DELAY_W-1:0]     r_cnt;
  logic [IDX_W-1:0]       r_idx;
  logic [NUM_CH-1:0]      r_out_reset;
  logic                   r_ready;
  logic [DELAY_W-1:0]     w_delay;
  logic                   w_restart;

  // Bring the asynchronous lock flag into the clk domain.
  // NOTE: state is written with non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours; blocking here would collapse the chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], in_locked};
    end
  end

  assign w_locked_s = r_sync[SYNC_STAGES-1];

  // Pick the release delay of the channel currently being sequenced.
  // NOTE: the default assignment first guarantees every path drives w_delay,
  // so no latch is inferred when r_idx matches no channel.
  always_comb begin
    w_delay = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_delay = RELEASE_DELAY[i*DELAY_W +: DELAY_W];
      end
    end
  end

  // Abort outside HOLD: soft reset always, lock loss once lock has been seen.
  always_comb begin
    w_restart = 1'b0;
    if (r_state != S_HOLD) begin
      w_restart = soft_reset || ((r_state != S_WAIT_LOCK) && !w_locked_s);
    end
  end

  // Sequencer: hold, wait for lock, release channels in order, then run.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_HOLD;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_out_reset <= '1;
      r_ready     <= 1'b0;
    end else if (w_restart) begin
      // An abort wins over any release that would have happened this cycle.
      r_state     <= S_HOLD;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_out_reset <= '1;
      r_ready     <= 1'b0;
    end else begin
      case (r_state)
        S_HOLD: begin
          if (soft_reset) begin
            r_cnt <= '0;
          end else if (r_cnt == HOLD_LAST) begin
            r_state <= S_WAIT_LOCK;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + DELAY_W'(1);
          end
        end
        S_WAIT_LOCK: begin
          if (w_locked_s) begin
            r_state <= S_RELEASE;
            r_idx   <= '0;
            r_cnt   <= '0;
          end
        end
        S_RELEASE: begin
          if (r_cnt == w_delay) begin
            r_out_reset[r_idx] <= 1'b0;
            r_cnt              <= '0;
            r_idx              <= r_idx + IDX_W'(1);
            if (r_idx == LAST_IDX) begin
              r_state <= S_RUN;
              r_ready <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + DELAY_W'(1);
          end
        end
        S_RUN: begin
          // Outputs hold until an abort or the raw reset.
        end
        default: begin
          r_state     <= S_HOLD;
          r_cnt       <= '0;
          r_idx       <= '0;
          r_out_reset <= '1;
          r_ready     <= 1'b0;
        end
      endcase
    end
  end

  assign out_reset = r_out_reset;
  assign ready     = r_ready;
  assign busy_cnt  = r_cnt;

endmodule

// File: tb/tb_reset_sequencer.sv
`timescale 1ns / 1ps
// Bench for reset_sequencer: expected output timelines are derived from the
// release timing rules (hold length, lock exit edge, per-channel delays),
// queued as stimulus is driven and compared edge by edge against the DUT.
module tb_reset_sequencer;

  localparam int HOLD = 16;

  typedef struct {
    int          n;
    logic [1:0]  rst;
    logic        rdy;
    logic [15:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_locked = 1'b0;
  logic        soft_reset = 1'b0;
  logic [1:0]  out_reset;
  logic        ready;
  logic [15:0] busy_cnt;
  logic [1:0]  z_out_reset;
  logic        z_ready;
  logic [15:0] z_busy_cnt;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  reset_sequencer #(
    .NUM_CH(2), .DELAY_W(16), .RELEASE_DELAY({16'd8, 16'd4}),
    .HOLD_CYCLES(HOLD), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .reset(reset), .in_locked(in_locked), .soft_reset(soft_reset),
    .out_reset(out_reset), .ready(ready), .busy_cnt(busy_cnt)
  );

  reset_sequencer #(
    .NUM_CH(2), .DELAY_W(16), .RELEASE_DELAY(32'd0),
    .HOLD_CYCLES(HOLD), .SYNC_STAGES(2)
  ) dut_zero (
    .clk(clk), .reset(reset), .in_locked(in_locked), .soft_reset(soft_reset),
    .out_reset(z_out_reset), .ready(z_ready), .busy_cnt(z_busy_cnt)
  );

  // Expected outputs n edges after a (re)start, given the edge e on which the
  // sequence leaves WAIT_LOCK and the two channel delays.
  function automatic exp_t exp_at(int n, int e, int d0, int d1);
    exp_t r;
    int   t0;
    int   t1;
    t0    = e + d0 + 1;
    t1    = t0 + d1 + 1;
    r.n   = n;
    r.rst = {logic'(n < t1), logic'(n < t0)};
    r.rdy = (n >= t1);
    if (n < HOLD)     r.cnt = 16'(n);
    else if (n <= e)  r.cnt = 16'd0;
    else if (n < t0)  r.cnt = 16'(n - e);
    else if (n < t1)  r.cnt = 16'(n - t0);
    else              r.cnt = 16'd0;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Assert the raw reset between edges and release it just after an edge,
  // so the next edge is edge 1 of the sequence.
  task automatic apply_reset(input logic locked);
    step();
    reset      = 1'b1;
    in_locked  = locked;
    soft_reset = 1'b0;
    repeat (3) step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    step();
    reset     = 1'b1;
    in_locked = 1'b1;
    #1;
    sb.push_back(exp_at(0, 17, 4, 8));
    e = sb.pop_front();
    n_checks++;
    if (out_reset !== e.rst || ready !== e.rdy || busy_cnt !== e.cnt) begin
      n_fail++;
      $display("FAIL reset_state: got out_reset=%b ready=%b busy_cnt=%0d, want %b %b %0d",
               out_reset, ready, busy_cnt, e.rst, e.rdy, e.cnt);
    end
  endtask

  // T1: lock present before reset drops.
  task automatic test_normal();
    exp_t e;
    apply_reset(1'b1);
    for (int n = 1; n <= 35; n++) sb.push_back(exp_at(n, 17, 4, 8));
    while (sb.size() > 0) begin
      step();
      e = sb.pop_front();
      n_checks++;
      if (out_reset !== e.rst || ready !== e.rdy || busy_cnt !== e.cnt) begin
        n_fail++;
        $display("FAIL normal[%0d]: got out_reset=%b ready=%b busy_cnt=%0d, want %b %b %0d",
                 e.n, out_reset, ready, busy_cnt, e.rst, e.rdy, e.cnt);
      end
    end
  endtask

  // T3: lock lost while running, then regained.
  task automatic test_lock_loss();
    exp_t e;
    exp_t run;
    run = exp_at(40, 17, 4, 8);
    in_locked = 1'b0;
    sb.push_back(run);
    sb.push_back(run);
    sb.push_back(exp_at(0, 17, 4, 8));
    while (sb.size() > 0) begin
      step();
      e = sb.pop_front();
      n_checks++;
      if (out_reset !== e.rst || ready !== e.rdy || busy_cnt !== e.cnt) begin
        n_fail++;
        $display("FAIL lock_loss: got out_reset=%b ready=%b busy_cnt=%0d, want %b %b %0d",
                 out_reset, ready, busy_cnt, e.rst, e.rdy, e.cnt);
      end
    end
    in_locked = 1'b1;
    for (int n = 1; n <= 35; n++) sb.push_back(exp_at(n, 17, 4, 8));
    while (sb.size() > 0) begin
      step();
      e = sb.pop_front();
      n_checks++;
      if (out_reset !== e.rst || ready !== e.rdy || busy_cnt !== e.cnt) begin
        n_fail++;
        $display("FAIL relock[%0d]: got out_reset=%b ready=%b busy_cnt=%0d, want %b %b %0d",
                 e.n, out_reset, ready, busy_cnt, e.rst, e.rdy, e.cnt);
      end
    end
  endtask

  // T2: lock arrives 100 cycles after reset; two sync edges plus one
  // WAIT_LOCK edge put the RELEASE entry on edge 103.
  task automatic test_late_lock();
    exp_t e;
    apply_reset(1'b0);
    for (int n = 1; n <= 100; n++) sb.push_back(exp_at(n, 103, 4, 8));
    while (sb.size() > 0) begin
      step();
      e = sb.pop_front();
      n_checks++;
      if (out_reset !== e.rst || ready !== e.rdy || busy_cnt !== e.cnt) begin
        n_fail++;
        $display("FAIL late_lock_wait[%0d]: got out_reset=%b ready=%b busy_cnt=%0d, want %b %b %0d",
                 e.n, out_reset, ready, busy_cnt, e.rst, e.rdy, e.cnt);
      end
    end
    in_locked = 1'b1;
    for (int n = 101; n <= 120; n++) sb.push_back(exp_at(n, 103, 4, 8));
    while (sb.size() > 0) begin
      step();
      e = sb.pop_front();
      n_checks++;
      if (out_reset !== e.rst || ready !== e.rdy || busy_cnt !== e.cnt) begin
        n_fail++;
        $display("FAIL late_lock_seq[%0d]: got out_reset=%b ready=%b busy_cnt=%0d, want %b %b %0d",
                 e.n, out_reset, ready, busy_cnt, e.rst, e.rdy, e.cnt);
      end
    end
  endtask

  // T4: one-cycle soft reset mid-release, then a 3-cycle soft reset in HOLD.
  task automatic test_soft_reset();
    exp_t e;
    apply_reset(1'b1);
    for (int n = 1; n <= 25; n++) sb.push_back(exp_at(n, 17, 4, 8));
    while (sb.size() > 0) begin
      step();
      e = sb.pop_front();
      n_checks++;
      if (out_reset !== e.rst || ready !== e.rdy || busy_cnt !== e.cnt) begin
        n_fail++;
        $display("FAIL soft_pre[%0d]: got out_reset=%b ready=%b busy_cnt=%0d, want %b %b %0d",
                 e.n, out_reset, ready, busy_cnt, e.rst, e.rdy, e.cnt);
      end
    end
    soft_reset = 1'b1;
    sb.push_back(exp_at(0, 17, 4, 8));
    step();
    soft_reset = 1'b0;
    for (int n = 1; n <= 4; n++) sb.push_back(exp_at(n, 17, 4, 8));
    for (int n = 0; n < 5; n++) begin
      if (n > 0) step();
      e = sb.pop_front();
      n_checks++;
      if (out_reset !== e.rst || ready !== e.rdy || busy_cnt !== e.cnt) begin
        n_fail++;
        $display("FAIL soft_abort[%0d]: got out_reset=%b ready=%b busy_cnt=%0d, want %b %b %0d",
                 e.n, out_reset, ready, busy_cnt, e.rst, e.rdy, e.cnt);
      end
    end
    soft_reset = 1'b1;
    repeat (3) sb.push_back(exp_at(0, 17, 4, 8));
    for (int k = 0; k < 3; k++) begin
      step();
      if (k == 2) soft_reset = 1'b0;
      e = sb.pop_front();
      n_checks++;
      if (out_reset !== e.rst || ready !== e.rdy || busy_cnt !== e.cnt) begin
        n_fail++;
        $display("FAIL soft_hold[%0d]: got out_reset=%b ready=%b busy_cnt=%0d, want %b %b %0d",
                 k, out_reset, ready, busy_cnt, e.rst, e.rdy, e.cnt);
      end
    end
    for (int n = 1; n <= 35; n++) sb.push_back(exp_at(n, 17, 4, 8));
    while (sb.size() > 0) begin
      step();
      e = sb.pop_front();
      n_checks++;
      if (out_reset !== e.rst || ready !== e.rdy || busy_cnt !== e.cnt) begin
        n_fail++;
        $display("FAIL soft_rerun[%0d]: got out_reset=%b ready=%b busy_cnt=%0d, want %b %b %0d",
                 e.n, out_reset, ready, busy_cnt, e.rst, e.rdy, e.cnt);
      end
    end
  endtask

  // T5: raw reset between edges, mid-release and again while running.
  task automatic test_async_reset();
    exp_t e;
    for (int pass = 0; pass < 2; pass++) begin
      apply_reset(1'b1);
      for (int n = 1; n <= ((pass == 0) ? 25 : 35); n++) sb.push_back(exp_at(n, 17, 4, 8));
      while (sb.size() > 0) begin
        step();
        e = sb.pop_front();
        n_checks++;
        if (out_reset !== e.rst || ready !== e.rdy || busy_cnt !== e.cnt) begin
          n_fail++;
          $display("FAIL async_pre%0d[%0d]: got out_reset=%b ready=%b busy_cnt=%0d, want %b %b %0d",
                   pass, e.n, out_reset, ready, busy_cnt, e.rst, e.rdy, e.cnt);
        end
      end
      #2;
      reset = 1'b1;
      sb.push_back(exp_at(0, 17, 4, 8));
      #1;
      e = sb.pop_front();
      n_checks++;
      if (out_reset !== e.rst || ready !== e.rdy || busy_cnt !== e.cnt) begin
        n_fail++;
        $display("FAIL async_mid%0d: got out_reset=%b ready=%b busy_cnt=%0d, want %b %b %0d",
                 pass, out_reset, ready, busy_cnt, e.rst, e.rdy, e.cnt);
      end
    end
  endtask

  // T6: zero delays release ch0 and ch1 on consecutive edges after lock exit.
  task automatic test_zero_delay();
    exp_t e;
    apply_reset(1'b1);
    for (int n = 1; n <= 22; n++) sb.push_back(exp_at(n, 17, 0, 0));
    while (sb.size() > 0) begin
      step();
      e = sb.pop_front();
      n_checks++;
      if (z_out_reset !== e.rst || z_ready !== e.rdy || z_busy_cnt !== e.cnt) begin
        n_fail++;
        $display("FAIL zero_delay[%0d]: got out_reset=%b ready=%b busy_cnt=%0d, want %b %b %0d",
                 e.n, z_out_reset, z_ready, z_busy_cnt, e.rst, e.rdy, e.cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_lock_loss();
    test_late_lock();
    test_soft_reset();
    test_async_reset();
    test_zero_delay();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks done", n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
